mux_arbiter4: RTL and testbench

MUX_ARBITER4 -- requirements
Module: mux_arbiter4

---
 rtl/mux_arbiter4_pkg.sv | 20 ++
 rtl/mux4to1.sv | 23 ++
 rtl/rr_pick4.sv | 32 +++
 rtl/mux_arbiter4.sv | 156 +++++++++++++++
 tb/tb_mux_arbiter4.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_arbiter4_pkg.sv
// Shared types and constants for the 4-requester round-robin mux arbiter.
//   state_e         : arbiter FSM state (IDLE, OWN)
//   TIMEOUT_DEFAULT : default no-progress cycle limit for the optional timeout
//   onehot4()       : binary owner index -> one-hot grant vector
package mux_arbiter4_pkg;

    localparam int unsigned NUM_REQ         = 4;
    localparam int unsigned IDX_W           = 2;
    localparam int unsigned TIMEOUT_DEFAULT = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    function automatic logic [NUM_REQ-1:0] onehot4(input logic [IDX_W-1:0] idx);
        onehot4 = NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux4to1.sv
// Four-way lane select.
//   d_i : four W-bit data lanes
//   s_i : binary lane index
//   y_o : selected lane (combinational)
module mux4to1 #(
    parameter int unsigned W = 64
) (
    input  logic [3:0][W-1:0] d_i,
    input  logic [1:0]        s_i,
    output logic [W-1:0]      y_o
);

    always_comb begin
        y_o = d_i[0];
        case (s_i)
            2'd0:    y_o = d_i[0];
            2'd1:    y_o = d_i[1];
            2'd2:    y_o = d_i[2];
            default: y_o = d_i[3];
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// Round-robin winner search over four requesters.
//   req_i   : request vector
//   ptr_i   : index of the last owner; search starts at ptr_i+1 and wraps
//   found_o : at least one request is pending
//   idx_o   : index of the first requester found
module rr_pick4
    import mux_arbiter4_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic [IDX_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit overwrites last.
    // Offset 4 wraps back to ptr_i itself, giving it lowest priority.
    always_comb begin
        found_o = 1'b0;
        idx_o   = ptr_i;
        cand    = ptr_i;
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            cand = ptr_i + IDX_W'(k);
            if (req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_arbiter4.sv
// Four-requester round-robin arbiter with burst ownership and data lane mux.
// A requester owns the output until its last beat transfers or it drops req;
// one IDLE cycle always separates consecutive grants.
// Optional feature: define MUX_ARBITER4_TIMEOUT_EN to force release of an
// owner that makes no progress for TIMEOUT cycles (timeout pulses once).
//   clk, reset : clock, synchronous active-high reset
//   req, last  : per-requester request and final-beat marker
//   in         : per-requester data lanes
//   out_ready  : downstream accepts the current beat
//   gnt, sel   : registered one-hot owner / binary owner index
//   out        : lane selected by sel (combinational)
//   out_valid  : owner's req while in OWN (combinational)
//   timeout    : one-cycle pulse on a forced release
module mux_arbiter4
    import mux_arbiter4_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [3:0]                 req,
    input  logic [3:0]                 last,
    input  logic [3:0][DATA_WIDTH-1:0] in,
    input  logic                       out_ready,
    output logic [3:0]                 gnt,
    output logic [1:0]                 sel,
    output logic [DATA_WIDTH-1:0]      out,
    output logic                       out_valid,
    output logic                       timeout
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [3:0]       gnt_q, gnt_d;
    logic             tmo_q, tmo_d;

    logic             found;
    logic [IDX_W-1:0] win_idx;
    logic             own;
    logic             xfer;
    logic             withdraw;
    logic             burst_done;
    logic             tmo_hit;
    logic             rel_own;

    rr_pick4 u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .found_o (found),
        .idx_o   (win_idx)
    );

    mux4to1 #(
        .W (DATA_WIDTH)
    ) u_mux (
        .d_i (in),
        .s_i (sel_q),
        .y_o (out)
    );

    // Owner-side handshake terms.
    assign own        = (state_q == OWN);
    assign out_valid  = own & req[sel_q];
    assign xfer       = out_valid & out_ready;
    assign withdraw   = own & ~req[sel_q];
    assign burst_done = xfer & last[sel_q];

`ifdef MUX_ARBITER4_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The TIMEOUT-th consecutive stalled OWN cycle forces release.
    assign tmo_hit = own & req[sel_q] & ~xfer & (cnt_q == CNT_W'(TIMEOUT - 1));

    // Stall counter: advances on stalled OWN cycles, cleared by any progress or release.
    always_comb begin
        cnt_d = '0;
        if (own && req[sel_q] && !xfer && !tmo_hit) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign rel_own = withdraw | burst_done | tmo_hit;

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(3);
            sel_q   <= '0;
            gnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found)   state_d = OWN;
            OWN:     if (rel_own) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and round-robin pointer.
    always_comb begin
        ptr_d = ptr_q;
        sel_d = sel_q;
        gnt_d = gnt_q;
        tmo_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d = win_idx;
                    gnt_d = onehot4(win_idx);
                end
            end
            OWN: begin
                if (rel_own) begin
                    ptr_d = sel_q;
                    gnt_d = '0;
                    tmo_d = tmo_hit;
                end
            end
            default: begin
                gnt_d = '0;
            end
        endcase
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign timeout = tmo_q;

endmodule

// File: tb/tb_mux_arbiter4.sv
// Testbench for mux_arbiter4: directed scenarios followed by random traffic,
// every cycle compared against a behavioural owner/pointer model.
module tb_mux_arbiter4;

    localparam int unsigned DW  = 64;
    localparam int          TMO = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [3:0]           req;
    logic [3:0]           last;
    logic [3:0][DW-1:0]   lanes;
    logic                 out_ready;
    logic [3:0]           gnt;
    logic [1:0]           sel;
    logic [DW-1:0]        out_w;
    logic                 out_valid;
    logic                 timeout;

    int checks   = 0;
    int failures = 0;

    // Reference model: current owner (-1 = none), last-owner pointer, select.
    int m_own = -1;
    int m_ptr = 3;
    int m_sel = 0;
    int m_cnt = 0;
    bit m_tmo = 1'b0;

    int         dut_xfers  = 0;
    int         tmo_pulses = 0;
    logic [3:0] gnt_prev   = 4'b0;
    int         grant_log[$];

    mux_arbiter4 #(
        .DATA_WIDTH (DW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .last      (last),
        .in        (lanes),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .out       (out_w),
        .out_valid (out_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic rdy);
        req       = r;
        last      = l;
        out_ready = rdy;
        for (int i = 0; i < 4; i++) lanes[i] = {$urandom, $urandom};
    endtask

    // Advance the model by one clock edge using the inputs present before it.
    task automatic model_step();
        int w;
        bit v;
        bit x;
        m_tmo = 1'b0;
        if (reset === 1'b1) begin
            m_own = -1;
            m_ptr = 3;
            m_sel = 0;
            m_cnt = 0;
        end else if (m_own < 0) begin
            w = -1;
            for (int k = 1; k <= 4; k++) begin
                if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            end
            if (w >= 0) begin
                m_own = w;
                m_sel = w;
                m_cnt = 0;
            end
        end else begin
            v = req[m_own];
            x = v && out_ready;
            if (!v) begin
                m_ptr = m_own;
                m_own = -1;
                m_cnt = 0;
            end else if (x && last[m_own]) begin
                m_ptr = m_own;
                m_own = -1;
                m_cnt = 0;
            end else if (x) begin
                m_cnt = 0;
            end else begin
`ifdef MUX_ARBITER4_TIMEOUT_EN
                m_cnt++;
                if (m_cnt == TMO) begin
                    m_ptr = m_own;
                    m_own = -1;
                    m_tmo = 1'b1;
                    m_cnt = 0;
                end
`endif
            end
        end
    endtask

    // One clock: settle, note handshake, step model, then compare all outputs.
    task automatic tick();
        logic [3:0] exp_gnt;
        logic       exp_valid;
        #2;
        if (out_valid === 1'b1 && out_ready === 1'b1 && reset === 1'b0) dut_xfers++;
        model_step();
        @(posedge clk);
        #1;
        if (timeout === 1'b1) tmo_pulses++;
        if (gnt != 4'b0 && gnt_prev == 4'b0) grant_log.push_back(int'(sel));
        gnt_prev  = gnt;
        exp_gnt   = (m_own < 0) ? 4'b0 : 4'(1 << m_own);
        exp_valid = (m_own >= 0) && req[m_own];
        chk("gnt",       DW'(gnt),       DW'(exp_gnt));
        chk("sel",       DW'(sel),       DW'(m_sel));
        chk("out_valid", DW'(out_valid), DW'(exp_valid));
        chk("out",       out_w,          lanes[m_sel]);
        chk("timeout",   DW'(timeout),   DW'(m_tmo));
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};
    int x0;

    initial begin
        // Reset state.
        reset = 1'b1;
        drive(4'b0000, 4'b0000, 1'b0);
        tick();
        tick();
        chk("rst_gnt", DW'(gnt), DW'(4'b0000));
        chk("rst_valid", DW'(out_valid), DW'(1'b0));
        reset = 1'b0;

        // Three-beat burst from requester 0.
        dut_xfers = 0;
        drive(4'b0001, 4'b0000, 1'b1);
        tick();
        chk("burst_grant", DW'(gnt), DW'(4'b0001));
        tick();
        drive(4'b0001, 4'b0000, 1'b1);
        tick();
        drive(4'b0001, 4'b0001, 1'b1);
        tick();
        chk("burst_xfers", DW'(dut_xfers), DW'(3));
        chk("burst_idle", DW'(gnt), DW'(4'b0000));
        // ptr is now 0, so requester 3 beats requester 0.
        drive(4'b1001, 4'b0000, 1'b1);
        tick();
        chk("burst_ptr", DW'(gnt), DW'(4'b1000));
        drive(4'b1000, 4'b1000, 1'b1);
        tick();
        drive(4'b0000, 4'b0000, 1'b0);
        tick();

        // All requesting with single-beat bursts: strict rotation.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        grant_log.delete();
        drive(4'b1111, 4'b1111, 1'b1);
        repeat (10) tick();
        drive(4'b0000, 4'b0000, 1'b0);
        tick();
        chk("rr_count", DW'(grant_log.size()), DW'(5));
        for (int i = 0; i < 5; i++) begin
            chk("rr_order", DW'((i < grant_log.size()) ? grant_log[i] : -1), DW'(exp_order[i]));
        end

        // Owner 2 stalls for five cycles then resumes.
        drive(4'b0100, 4'b0000, 1'b0);
        tick();
        chk("stall_grant", DW'(gnt), DW'(4'b0100));
        repeat (5) begin
            drive(4'b0100, 4'b0000, 1'b0);
            tick();
            chk("stall_hold", DW'(gnt), DW'(4'b0100));
        end
        x0 = dut_xfers;
        drive(4'b0100, 4'b0000, 1'b1);
        tick();
        tick();
        drive(4'b0100, 4'b0100, 1'b1);
        tick();
        chk("stall_resume", DW'(dut_xfers - x0), DW'(3));
        drive(4'b0000, 4'b0000, 1'b0);
        tick();

        // Owner 1 withdraws mid-burst; next search starts at 2.
        drive(4'b0010, 4'b0000, 1'b1);
        tick();
        chk("wd_grant", DW'(gnt), DW'(4'b0010));
        tick();
        drive(4'b1001, 4'b0000, 1'b1);
        tick();
        chk("wd_idle", DW'(gnt), DW'(4'b0000));
        chk("wd_tmo", DW'(timeout), DW'(1'b0));
        tick();
        chk("wd_next", DW'(gnt), DW'(4'b1000));
        drive(4'b1000, 4'b1000, 1'b1);
        tick();
        drive(4'b0000, 4'b0000, 1'b0);
        tick();

        // Owner 0 never gets out_ready.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tmo_pulses = 0;
        drive(4'b0001, 4'b0000, 1'b0);
        repeat (20) tick();
`ifdef MUX_ARBITER4_TIMEOUT_EN
        chk("tmo_pulses", DW'(tmo_pulses), DW'(1));
`else
        chk("tmo_pulses", DW'(tmo_pulses), DW'(0));
        chk("tmo_hold", DW'(gnt), DW'(4'b0001));
`endif
        drive(4'b0000, 4'b0000, 1'b0);
        tick();
        tick();

        // Reset during beat 2 of a four-beat burst.
        drive(4'b0001, 4'b0000, 1'b1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("rstmid_gnt", DW'(gnt), DW'(4'b0000));
        chk("rstmid_valid", DW'(out_valid), DW'(1'b0));
        reset = 1'b0;
        drive(4'b1111, 4'b0000, 1'b1);
        tick();
        chk("rstmid_win", DW'(gnt), DW'(4'b0001));
        drive(4'b0000, 4'b0000, 1'b0);
        tick();
        tick();

        // Random traffic with occasional reset.
        repeat (400) begin
            reset = ($urandom_range(0, 63) == 0);
            drive(4'($urandom), 4'($urandom), 1'($urandom));
            tick();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
